// File: rtl/sensor_fusion_host_ctrl.sv
// Host-side sequencer that drives a sensor-fusion accelerator over AXI4-Lite.
// Each command writes ctrl=1, polls status until bit0 is set (or the poll
// budget runs out), writes ctrl=0, then reads the fused position and velocity.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   cmd_start               run request, sampled only while idle
//   busy, done              busy outside IDLE; one-cycle completion pulse
//   err, err_code           error flag and cause (01 bad response, 10 poll timeout)
//   result_pos, result_vel  last successfully read fused state
//   m_axi_*                 AXI4-Lite master write and read channels
module sensor_fusion_host_ctrl #(
   parameter int unsigned AXI_ADDR_W = 4,
   parameter int unsigned AXI_DATA_W = 32,
   parameter int unsigned POLL_LIMIT = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_start,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [1:0]            err_code,
   output logic [AXI_DATA_W-1:0] result_pos,
   output logic [AXI_DATA_W-1:0] result_vel,
   output logic                  m_axi_awvalid,
   output logic [AXI_ADDR_W-1:0] m_axi_awaddr,
   input  logic                  m_axi_awready,
   output logic                  m_axi_wvalid,
   output logic [AXI_DATA_W-1:0] m_axi_wdata,
   input  logic                  m_axi_wready,
   input  logic                  m_axi_bvalid,
   input  logic [1:0]            m_axi_bresp,
   output logic                  m_axi_bready,
   output logic                  m_axi_arvalid,
   output logic [AXI_ADDR_W-1:0] m_axi_araddr,
   input  logic                  m_axi_arready,
   input  logic                  m_axi_rvalid,
   input  logic [AXI_DATA_W-1:0] m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   output logic                  m_axi_rready
);

   localparam int unsigned CNT_W = $clog2(POLL_LIMIT + 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] WADDR  = 3'd1;
   localparam logic [2:0] WRESP  = 3'd2;
   localparam logic [2:0] RADDR  = 3'd3;
   localparam logic [2:0] RDATA  = 3'd4;
   localparam logic [2:0] FINISH = 3'd5;

   localparam logic [2:0] STEP_CTRL_ON  = 3'd0;
   localparam logic [2:0] STEP_POLL     = 3'd1;
   localparam logic [2:0] STEP_CTRL_OFF = 3'd2;
   localparam logic [2:0] STEP_POS      = 3'd3;
   localparam logic [2:0] STEP_VEL      = 3'd4;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_RESP    = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   localparam logic [AXI_ADDR_W-1:0] ADDR_CTRL   = AXI_ADDR_W'(4'h0);
   localparam logic [AXI_ADDR_W-1:0] ADDR_STATUS = AXI_ADDR_W'(4'h4);
   localparam logic [AXI_ADDR_W-1:0] ADDR_POS    = AXI_ADDR_W'(4'h8);
   localparam logic [AXI_ADDR_W-1:0] ADDR_VEL    = AXI_ADDR_W'(4'hC);

   logic [2:0]            state, state_n, step, step_n;
   logic [CNT_W-1:0]      poll_cnt, poll_cnt_n;
   logic                  awvalid_n, wvalid_n, bready_n, arvalid_n, rready_n, err_n;
   logic [AXI_ADDR_W-1:0] awaddr_n, araddr_n;
   logic [AXI_DATA_W-1:0] wdata_n, pos_n, vel_n;
   logic [1:0]            err_code_n;

   // A channel is finished once its valid has dropped or is accepted this cycle.
   logic             aw_done_c, w_done_c, poll_hit_c;
   logic [CNT_W-1:0] poll_inc_c;
   assign aw_done_c  = !m_axi_awvalid || m_axi_awready;
   assign w_done_c   = !m_axi_wvalid || m_axi_wready;
   assign poll_inc_c = poll_cnt + CNT_W'(1);
   assign poll_hit_c = (poll_inc_c == CNT_W'(POLL_LIMIT));

   // Next-state and next-output logic; every register holds by default.
   always_comb begin
      state_n    = state;
      step_n     = step;
      poll_cnt_n = poll_cnt;
      awvalid_n  = m_axi_awvalid;
      wvalid_n   = m_axi_wvalid;
      awaddr_n   = m_axi_awaddr;
      wdata_n    = m_axi_wdata;
      bready_n   = m_axi_bready;
      arvalid_n  = m_axi_arvalid;
      araddr_n   = m_axi_araddr;
      rready_n   = m_axi_rready;
      err_n      = err;
      err_code_n = err_code;
      pos_n      = result_pos;
      vel_n      = result_vel;
      case (state)
         IDLE: begin
            if (cmd_start) begin
               state_n    = WADDR;
               step_n     = STEP_CTRL_ON;
               poll_cnt_n = '0;
               err_n      = 1'b0;
               err_code_n = ERR_NONE;
               awvalid_n  = 1'b1;
               wvalid_n   = 1'b1;
               awaddr_n   = ADDR_CTRL;
               wdata_n    = AXI_DATA_W'(1);
            end
         end
         WADDR: begin
            awvalid_n = m_axi_awvalid && !m_axi_awready;
            wvalid_n  = m_axi_wvalid && !m_axi_wready;
            if (aw_done_c && w_done_c) begin
               state_n  = WRESP;
               bready_n = 1'b1;
            end
         end
         WRESP: begin
            if (m_axi_bvalid) begin
               bready_n = 1'b0;
               if (m_axi_bresp != 2'b00) begin
                  state_n    = FINISH;
                  err_code_n = ERR_RESP;
               end else if (step == STEP_CTRL_ON) begin
                  state_n   = RADDR;
                  step_n    = STEP_POLL;
                  arvalid_n = 1'b1;
                  araddr_n  = ADDR_STATUS;
               end else if (err_code == ERR_TIMEOUT) begin
                  state_n = FINISH;
               end else begin
                  state_n   = RADDR;
                  step_n    = STEP_POS;
                  arvalid_n = 1'b1;
                  araddr_n  = ADDR_POS;
               end
            end
         end
         RADDR: begin
            if (m_axi_arready) begin
               state_n   = RDATA;
               arvalid_n = 1'b0;
               rready_n  = 1'b1;
            end
         end
         RDATA: begin
            if (m_axi_rvalid) begin
               rready_n = 1'b0;
               if (m_axi_rresp != 2'b00) begin
                  state_n    = FINISH;
                  err_code_n = ERR_RESP;
               end else begin
                  case (step)
                     STEP_POLL: begin
                        // Timeout still writes ctrl=0 so the accelerator is left stopped.
                        if (m_axi_rdata[0] || poll_hit_c) begin
                           if (!m_axi_rdata[0]) begin
                              poll_cnt_n = poll_inc_c;
                              err_code_n = ERR_TIMEOUT;
                           end
                           state_n   = WADDR;
                           step_n    = STEP_CTRL_OFF;
                           awvalid_n = 1'b1;
                           wvalid_n  = 1'b1;
                           awaddr_n  = ADDR_CTRL;
                           wdata_n   = '0;
                        end else begin
                           poll_cnt_n = poll_inc_c;
                           state_n    = RADDR;
                           arvalid_n  = 1'b1;
                        end
                     end
                     STEP_POS: begin
                        pos_n     = m_axi_rdata;
                        state_n   = RADDR;
                        step_n    = STEP_VEL;
                        arvalid_n = 1'b1;
                        araddr_n  = ADDR_VEL;
                     end
                     default: begin
                        vel_n   = m_axi_rdata;
                        state_n = FINISH;
                     end
                  endcase
               end
            end
         end
         default: state_n = IDLE;
      endcase
      if (state_n == FINISH) err_n = (err_code_n != ERR_NONE);
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         step          <= STEP_CTRL_ON;
         poll_cnt      <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
         err_code      <= ERR_NONE;
         result_pos    <= '0;
         result_vel    <= '0;
         m_axi_awvalid <= 1'b0;
         m_axi_awaddr  <= '0;
         m_axi_wvalid  <= 1'b0;
         m_axi_wdata   <= '0;
         m_axi_bready  <= 1'b0;
         m_axi_arvalid <= 1'b0;
         m_axi_araddr  <= '0;
         m_axi_rready  <= 1'b0;
      end else begin
         state         <= state_n;
         step          <= step_n;
         poll_cnt      <= poll_cnt_n;
         busy          <= (state_n != IDLE);
         done          <= (state_n == FINISH);
         err           <= err_n;
         err_code      <= err_code_n;
         result_pos    <= pos_n;
         result_vel    <= vel_n;
         m_axi_awvalid <= awvalid_n;
         m_axi_awaddr  <= awaddr_n;
         m_axi_wvalid  <= wvalid_n;
         m_axi_wdata   <= wdata_n;
         m_axi_bready  <= bready_n;
         m_axi_arvalid <= arvalid_n;
         m_axi_araddr  <= araddr_n;
         m_axi_rready  <= rready_n;
      end
   end

endmodule

// File: tb/tb_sensor_fusion_host_ctrl.sv
// Directed testbench for sensor_fusion_host_ctrl with a behavioural AXI4-Lite
// accelerator model (programmable awready delay, status completion, error reads).
module tb_sensor_fusion_host_ctrl;

   localparam int unsigned AW = 4;
   localparam int unsigned DW = 32;
   localparam int unsigned PL = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_start = 1'b0;
   logic          busy, done, err;
   logic [1:0]    err_code;
   logic [DW-1:0] result_pos, result_vel;
   logic          m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
   logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
   logic [DW-1:0] m_axi_wdata, m_axi_rdata;
   logic          m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
   logic          m_axi_rvalid, m_axi_rready;
   logic [1:0]    m_axi_bresp, m_axi_rresp;

   int vec = 0;
   int miss = 0;

   always #5 clk = ~clk;

   sensor_fusion_host_ctrl #(.AXI_ADDR_W(AW), .AXI_DATA_W(DW), .POLL_LIMIT(PL)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .busy(busy), .done(done),
      .err(err), .err_code(err_code), .result_pos(result_pos), .result_vel(result_vel),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awready(m_axi_awready),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wdata(m_axi_wdata), .m_axi_wready(m_axi_wready),
      .m_axi_bvalid(m_axi_bvalid), .m_axi_bresp(m_axi_bresp), .m_axi_bready(m_axi_bready),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_araddr(m_axi_araddr), .m_axi_arready(m_axi_arready),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rready(m_axi_rready)
   );

   // Responder configuration (written only by the stimulus process).
   int          aw_delay = 0;
   int          done_at = 3;
   int          rerr_at = 0;
   int          status_base = 0;
   logic [31:0] pos_val = 32'h0;
   logic [31:0] vel_val = 32'h0;

   // Responder state.
   int          aw_cyc;
   logic        got_aw, got_w;
   logic [3:0]  aw_l, ar_l;
   logic [31:0] w_l;
   wire hs_aw  = m_axi_awvalid & m_axi_awready;
   wire hs_w   = m_axi_wvalid & m_axi_wready;
   wire hs_ar  = m_axi_arvalid & m_axi_arready;
   wire hs_r   = m_axi_rvalid & m_axi_rready;
   wire aw_seen = got_aw | hs_aw;
   wire w_seen  = got_w | hs_w;
   assign m_axi_awready = (aw_cyc >= aw_delay);
   assign m_axi_wready  = 1'b1;
   assign m_axi_arready = 1'b1;

   // Monitor counters: monotonic, never reset, read as deltas.
   int aw_hi = 0, w_hi = 0, act_hi = 0, done_cnt = 0, ovl = 0, status_rd = 0;
   logic [36:0] log_q[$];

   function automatic logic [33:0] rd_model(input logic [3:0] a);
      int idx;
      idx = status_rd - status_base + 1;
      case (a)
         4'h4:    rd_model = {((idx == rerr_at) ? 2'b10 : 2'b00), 31'd0, (idx == done_at)};
         4'h8:    rd_model = {2'b00, pos_val};
         4'hC:    rd_model = {2'b00, vel_val};
         default: rd_model = {2'b00, 32'hDEADBEEF};
      endcase
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_cyc <= 0; got_aw <= 1'b0; got_w <= 1'b0;
         aw_l <= '0; ar_l <= '0; w_l <= '0;
         m_axi_bvalid <= 1'b0; m_axi_bresp <= 2'b00;
         m_axi_rvalid <= 1'b0; m_axi_rdata <= '0; m_axi_rresp <= 2'b00;
      end else begin
         aw_cyc <= hs_aw ? 0 : (m_axi_awvalid ? aw_cyc + 1 : 0);
         if (hs_aw) aw_l <= m_axi_awaddr;
         if (hs_w)  w_l  <= m_axi_wdata;
         if (aw_seen && w_seen) begin
            got_aw <= 1'b0; got_w <= 1'b0;
            m_axi_bvalid <= 1'b1; m_axi_bresp <= 2'b00;
         end else begin
            got_aw <= aw_seen; got_w <= w_seen;
            if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
         end
         if (hs_ar) begin
            ar_l <= m_axi_araddr;
            m_axi_rvalid <= 1'b1;
            {m_axi_rresp, m_axi_rdata} <= rd_model(m_axi_araddr);
         end else if (hs_r) begin
            m_axi_rvalid <= 1'b0;
         end
      end
   end

   // Transaction log entries are {is_write, addr, data}.
   always @(posedge clk) begin
      if (m_axi_awvalid) aw_hi <= aw_hi + 1;
      if (m_axi_wvalid)  w_hi  <= w_hi + 1;
      if (m_axi_awvalid | m_axi_wvalid | m_axi_arvalid) act_hi <= act_hi + 1;
      if (done) done_cnt <= done_cnt + 1;
      if ((m_axi_awvalid | m_axi_wvalid | m_axi_bready) && (m_axi_arvalid | m_axi_rready))
         ovl <= ovl + 1;
      if (hs_ar && m_axi_araddr == 4'h4) status_rd <= status_rd + 1;
      if (rst_n && aw_seen && w_seen)
         log_q.push_back({1'b1, (hs_aw ? m_axi_awaddr : aw_l), (hs_w ? m_axi_wdata : w_l)});
      if (rst_n && hs_r) log_q.push_back({1'b0, ar_l, m_axi_rdata});
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Leaves the bench at the negedge after the sampling edge (cycle 1).
   task automatic pulse_start();
      cmd_start = 1'b1;
      tick();
      cmd_start = 1'b0;
   endtask

   task automatic wait_done(input int n0, input int limit, output int n);
      n = n0;
      while (!done && n < limit) begin
         tick();
         n++;
      end
      vec++;
      if (!done) begin
         miss++;
         $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, n);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(); tick();
      vec++;
      if ({busy, done, err, err_code} !== 5'b0) begin
         miss++;
         $display("FAIL reset_status: busy/done/err/code=%b required 00000", {busy, done, err, err_code});
      end
      vec++;
      if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready} !== 5'b0) begin
         miss++;
         $display("FAIL reset_handshake: aw/w/b/ar/r=%b required 00000",
                  {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready});
      end
      vec++;
      if ({result_pos, result_vel, m_axi_awaddr, m_axi_wdata, m_axi_araddr} !== '0) begin
         miss++;
         $display("FAIL reset_data: pos=%h vel=%h awaddr=%h wdata=%h araddr=%h required all zero",
                  result_pos, result_vel, m_axi_awaddr, m_axi_wdata, m_axi_araddr);
      end
      rst_n = 1'b1;
      repeat (3) tick();
      vec++;
      if ({busy, m_axi_awvalid, m_axi_arvalid} !== 3'b0) begin
         miss++;
         $display("FAIL idle_after_reset: busy/aw/ar=%b required 000", {busy, m_axi_awvalid, m_axi_arvalid});
      end
   endtask

   task automatic test_nominal();
      int n, base;
      logic [36:0] exp_log[7];
      exp_log = '{{1'b1, 4'h0, 32'h1}, {1'b0, 4'h4, 32'h0}, {1'b0, 4'h4, 32'h0},
                  {1'b0, 4'h4, 32'h1}, {1'b1, 4'h0, 32'h0}, {1'b0, 4'h8, 32'h00001234},
                  {1'b0, 4'hC, 32'hFFFF0010}};
      done_at = 3; rerr_at = 0; pos_val = 32'h00001234; vel_val = 32'hFFFF0010;
      status_base = status_rd; base = log_q.size();
      pulse_start();
      vec++;
      if ({busy, m_axi_awvalid, m_axi_wvalid, m_axi_awaddr, m_axi_wdata} !== {3'b111, 4'h0, 32'h1}) begin
         miss++;
         $display("FAIL first_write: busy/aw/w=%b addr=%h data=%h required 111 0 1",
                  {busy, m_axi_awvalid, m_axi_wvalid}, m_axi_awaddr, m_axi_wdata);
      end
      wait_done(1, 40, n);
      vec++;
      if (n !== 15) begin
         miss++;
         $display("FAIL nominal_latency: done at cycle %0d required 15", n);
      end
      vec++;
      if (log_q.size() - base !== 7) begin
         miss++;
         $display("FAIL nominal_txn_count: %0d transactions required 7", log_q.size() - base);
      end
      for (int i = 0; i < 7; i++) begin
         if (base + i < log_q.size()) begin
            vec++;
            if (log_q[base + i] !== exp_log[i]) begin
               miss++;
               $display("FAIL nominal_txn[%0d]: got %h required %h", i, log_q[base + i], exp_log[i]);
            end
         end
      end
      vec++;
      if ({result_pos, result_vel, err, err_code} !== {32'h00001234, 32'hFFFF0010, 3'b000}) begin
         miss++;
         $display("FAIL nominal_result: pos=%h vel=%h err=%b code=%b required 00001234 ffff0010 0 00",
                  result_pos, result_vel, err, err_code);
      end
      tick();
      vec++;
      if ({done, busy} !== 2'b00) begin
         miss++;
         $display("FAIL done_pulse_width: done/busy=%b one cycle after done, required 00", {done, busy});
      end
   endtask

   task automatic test_aw_delay();
      int n, base, a0, w0;
      aw_delay = 3; done_at = 1; rerr_at = 0; pos_val = 32'hAAAA0001; vel_val = 32'h55550002;
      status_base = status_rd; base = log_q.size(); a0 = aw_hi; w0 = w_hi;
      pulse_start();
      tick();
      vec++;
      if ({m_axi_awvalid, m_axi_wvalid} !== 2'b10) begin
         miss++;
         $display("FAIL aw_delay_wdrop: aw/w=%b at cycle 2 required 10", {m_axi_awvalid, m_axi_wvalid});
      end
      n = 0;
      while (log_q.size() == base && n < 20) begin
         tick();
         n++;
      end
      vec++;
      if ({aw_hi - a0, w_hi - w0} !== {32'd4, 32'd1}) begin
         miss++;
         $display("FAIL aw_delay_valid_cycles: awvalid %0d wvalid %0d cycles required 4 and 1",
                  aw_hi - a0, w_hi - w0);
      end
      vec++;
      if (log_q.size() - base !== 1 || log_q[base] !== {1'b1, 4'h0, 32'h1}) begin
         miss++;
         $display("FAIL aw_delay_single_write: %0d entries, first %h, required 1 entry 100000001",
                  log_q.size() - base, (log_q.size() > base) ? log_q[base] : 37'h0);
      end
      wait_done(1, 60, n);
      vec++;
      if ({log_q.size() - base, result_pos, result_vel} !== {32'd5, 32'hAAAA0001, 32'h55550002}) begin
         miss++;
         $display("FAIL aw_delay_result: %0d txns pos=%h vel=%h required 5 aaaa0001 55550002",
                  log_q.size() - base, result_pos, result_vel);
      end
      aw_delay = 0;
      tick();
   endtask

   task automatic test_poll_timeout();
      int n, base;
      logic [36:0] exp_log[6];
      exp_log = '{{1'b1, 4'h0, 32'h1}, {1'b0, 4'h4, 32'h0}, {1'b0, 4'h4, 32'h0},
                  {1'b0, 4'h4, 32'h0}, {1'b0, 4'h4, 32'h0}, {1'b1, 4'h0, 32'h0}};
      done_at = 0; rerr_at = 0; pos_val = 32'h11111111; vel_val = 32'h22222222;
      status_base = status_rd; base = log_q.size();
      pulse_start();
      wait_done(1, 40, n);
      vec++;
      if ({n, err, err_code} !== {32'd13, 3'b110}) begin
         miss++;
         $display("FAIL timeout_done: cycle %0d err=%b code=%b required 13 1 10", n, err, err_code);
      end
      vec++;
      if (log_q.size() - base !== 6) begin
         miss++;
         $display("FAIL timeout_txn_count: %0d transactions required 6", log_q.size() - base);
      end
      for (int i = 0; i < 6; i++) begin
         if (base + i < log_q.size()) begin
            vec++;
            if (log_q[base + i] !== exp_log[i]) begin
               miss++;
               $display("FAIL timeout_txn[%0d]: got %h required %h", i, log_q[base + i], exp_log[i]);
            end
         end
      end
      vec++;
      if ({result_pos, result_vel} !== {32'hAAAA0001, 32'h55550002}) begin
         miss++;
         $display("FAIL timeout_results_held: pos=%h vel=%h required aaaa0001 55550002",
                  result_pos, result_vel);
      end
      tick();
   endtask

   task automatic test_bad_resp();
      int n, base, a0;
      done_at = 3; rerr_at = 1;
      status_base = status_rd; base = log_q.size();
      pulse_start();
      wait_done(1, 40, n);
      vec++;
      if ({n, err, err_code} !== {32'd5, 3'b101}) begin
         miss++;
         $display("FAIL bad_resp_done: cycle %0d err=%b code=%b required 5 1 01", n, err, err_code);
      end
      vec++;
      if (log_q.size() - base !== 2) begin
         miss++;
         $display("FAIL bad_resp_txn_count: %0d transactions required 2", log_q.size() - base);
      end
      a0 = act_hi; base = log_q.size();
      repeat (10) tick();
      vec++;
      if ({act_hi - a0, log_q.size() - base} !== {32'd0, 32'd0}) begin
         miss++;
         $display("FAIL bad_resp_quiet: %0d valid cycles %0d txns after abort required 0 0",
                  act_hi - a0, log_q.size() - base);
      end
      vec++;
      if ({err, err_code, busy} !== 4'b1010) begin
         miss++;
         $display("FAIL err_held: err/code/busy=%b required 1010", {err, err_code, busy});
      end
      rerr_at = 0;
   endtask

   task automatic test_cmd_ignored();
      int n, base, d0;
      done_at = 3; rerr_at = 0; pos_val = 32'h0BADF00D; vel_val = 32'h00C0FFEE;
      status_base = status_rd; base = log_q.size(); d0 = done_cnt;
      pulse_start();
      vec++;
      if ({err, err_code} !== 3'b000) begin
         miss++;
         $display("FAIL err_clear_on_start: err/code=%b required 000", {err, err_code});
      end
      repeat (3) tick();
      cmd_start = 1'b1;
      tick(); tick();
      cmd_start = 1'b0;
      wait_done(6, 40, n);
      vec++;
      if (n !== 15) begin
         miss++;
         $display("FAIL ignored_latency: done at cycle %0d required 15", n);
      end
      repeat (20) tick();
      vec++;
      if ({done_cnt - d0, log_q.size() - base} !== {32'd1, 32'd7}) begin
         miss++;
         $display("FAIL ignored_single_run: %0d done pulses %0d txns required 1 and 7",
                  done_cnt - d0, log_q.size() - base);
      end
      vec++;
      if ({busy, result_pos, result_vel} !== {1'b0, 32'h0BADF00D, 32'h00C0FFEE}) begin
         miss++;
         $display("FAIL ignored_result: busy=%b pos=%h vel=%h required 0 0badf00d 00c0ffee",
                  busy, result_pos, result_vel);
      end
   endtask

   task automatic test_reset_mid();
      int n, a0;
      done_at = 3; status_base = status_rd;
      pulse_start();
      n = 0;
      while (!m_axi_arvalid && n < 10) begin
         tick();
         n++;
      end
      vec++;
      if (m_axi_arvalid !== 1'b1) begin
         miss++;
         $display("FAIL reset_mid_arvalid_seen: arvalid=%b required 1", m_axi_arvalid);
      end
      #1 rst_n = 1'b0;
      #1;
      vec++;
      if ({m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, busy, done} !== 6'b0) begin
         miss++;
         $display("FAIL reset_mid_async: ar/r/aw/w/busy/done=%b required 000000",
                  {m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, busy, done});
      end
      vec++;
      if ({result_pos, result_vel} !== 64'h0) begin
         miss++;
         $display("FAIL reset_mid_results: pos=%h vel=%h required 0 0", result_pos, result_vel);
      end
      tick(); tick();
      rst_n = 1'b1;
      a0 = act_hi;
      repeat (10) tick();
      vec++;
      if ({act_hi - a0, 31'd0, busy} !== 64'h0) begin
         miss++;
         $display("FAIL reset_mid_idle: %0d valid cycles busy=%b after release required 0 0",
                  act_hi - a0, busy);
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_aw_delay();
      test_poll_timeout();
      test_bad_resp();
      test_cmd_ignored();
      test_reset_mid();
      vec++;
      if (ovl !== 0) begin
         miss++;
         $display("FAIL rw_overlap: %0d cycles with read and write both outstanding, required 0", ovl);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
